// File: rtl/mt9v034_capture.sv
// Single-frame capture front end for an MT9V034 parallel sensor: registers the
// camera bus once, then emits qualified pixels with x/y coordinates and frame/line errors.
module mt9v034_capture #(
   parameter int WIDTH  = 752,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic        cam_fv,
   input  logic        cam_lv,
   input  logic [9:0]  cam_dout,
   output logic [9:0]  pix_data,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        sof,
   output logic        eol,
   output logic        done,
   output logic        busy,
   output logic        err_len,
   output logic        err_lines,
   output logic [15:0] frame_cnt,
   output logic [1:0]  state_dbg
);

   // Output pipeline: pix_valid/pix_data/pix_x/pix_y/sof/eol/done are registered
   // one cycle after the S1-stage decision that produces them, so cam_dout -> pix_data is 2 cycles.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_FV_LOW  = 2'd1,
      WAIT_FV_HIGH = 2'd2,
      CAPTURE      = 2'd3
   } state_t;

   state_t      state, state_next;

   logic        fv_s1, lv_s1, fv_d, lv_d;
   logic [9:0]  dout_s1;
   logic [9:0]  x_cnt, y_cnt, x_cur, y_cur, y_lines;
   logic        sof_pend;

   logic        fv_rise, fv_fall, lv_fall;
   logic        arm_take, start_cap, accept, line_end, frame_end;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == 10'h3FF) ? v : v + 10'd1;
   endfunction

   assign fv_rise = fv_s1 & ~fv_d;
   assign fv_fall = ~fv_s1 & fv_d;
   assign lv_fall = ~lv_s1 & lv_d;

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         fv_s1   <= 1'b0;
         lv_s1   <= 1'b0;
         dout_s1 <= '0;
         fv_d    <= 1'b0;
         lv_d    <= 1'b0;
      end else begin
         fv_s1   <= cam_fv;
         lv_s1   <= cam_lv;
         dout_s1 <= cam_dout;
         fv_d    <= fv_s1;
         lv_d    <= lv_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // The fv rising-edge cycle already accepts pixels so a line starting with fv is not clipped.
   always_comb begin
      state_next = state;
      arm_take   = 1'b0;
      start_cap  = 1'b0;
      accept     = 1'b0;
      line_end   = 1'b0;
      frame_end  = 1'b0;
      case (state)
         IDLE: begin
            if (arm) begin
               arm_take   = 1'b1;
               state_next = WAIT_FV_LOW;
            end
         end
         WAIT_FV_LOW: begin
            if (!fv_s1) state_next = WAIT_FV_HIGH;
         end
         WAIT_FV_HIGH: begin
            if (fv_rise) begin
               start_cap  = 1'b1;
               accept     = lv_s1;
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            accept    = fv_s1 & lv_s1;
            line_end  = lv_fall;
            frame_end = fv_fall;
            if (fv_fall) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign x_cur   = start_cap ? 10'd0 : x_cnt;
   assign y_cur   = start_cap ? 10'd0 : y_cnt;
   // A line closing together with the frame is counted before the height check.
   assign y_lines = line_end ? sat_inc(y_cnt) : y_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         done      <= 1'b0;
         err_len   <= 1'b0;
         err_lines <= 1'b0;
         frame_cnt <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         sof_pend  <= 1'b0;
      end else begin
         pix_valid <= accept;
         sof       <= accept & (start_cap | sof_pend);
         eol       <= line_end;
         done      <= frame_end;

         if (accept) begin
            pix_data <= dout_s1;
            pix_x    <= x_cur;
            pix_y    <= y_cur;
         end

         if (accept)                      x_cnt <= sat_inc(x_cur);
         else if (line_end || start_cap)  x_cnt <= '0;

         if (start_cap)     y_cnt <= '0;
         else if (line_end) y_cnt <= sat_inc(y_cnt);

         if (start_cap)   sof_pend <= ~accept;
         else if (accept) sof_pend <= 1'b0;

         if (arm_take)                                  err_len <= 1'b0;
         else if (line_end && (x_cnt != 10'(WIDTH)))    err_len <= 1'b1;

         if (arm_take)                                  err_lines <= 1'b0;
         else if (frame_end && (y_lines != 10'(HEIGHT))) err_lines <= 1'b1;

         if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_mt9v034_capture.sv
// Bench for mt9v034_capture on a reduced 8x6 geometry: frames are described as
// lists of line lengths and the expected pixel stream is queued as they are driven.
module tb_mt9v034_capture;
  localparam int WIDTH_P  = 8;
  localparam int HEIGHT_P = 6;
  localparam int W = 31;  // {sof, y, x, data}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        cam_fv = 1'b0;
  logic        cam_lv = 1'b0;
  logic [9:0]  cam_dout = '0;
  logic [9:0]  pix_data, pix_x, pix_y;
  logic        pix_valid, sof, eol, done, busy, err_len, err_lines;
  logic [15:0] frame_cnt;
  logic [1:0]  state_dbg;

  mt9v034_capture #(.WIDTH(WIDTH_P), .HEIGHT(HEIGHT_P)) dut (
    .clk(clk), .reset(reset), .arm(arm), .cam_fv(cam_fv), .cam_lv(cam_lv),
    .cam_dout(cam_dout), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol), .done(done),
    .busy(busy), .err_len(err_len), .err_lines(err_lines),
    .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int pix_cnt = 0, eol_cnt = 0, done_cnt = 0;
  int last_eol_cyc = -1, done_cyc = -2;
  logic [9:0] last_x, last_y;
  logic [15:0] exp_fc = '0;
  int lens[16];

  always @(negedge clk) begin
    if (pix_valid) begin
      logic [W-1:0] e;
      vectors++;
      pix_cnt++;
      last_x = pix_x;
      last_y = pix_y;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pixel: got sof=%0b y=%0d x=%0d d=%h, none expected", sof, pix_y, pix_x, pix_data);
        miscompares++;
      end else begin
        e = exp_q.pop_front();
        if ({sof, pix_y, pix_x, pix_data} !== e) begin
          $display("FAIL pixel: got sof=%0b y=%0d x=%0d d=%h want sof=%0b y=%0d x=%0d d=%h",
                   sof, pix_y, pix_x, pix_data, e[30], e[29:20], e[19:10], e[9:0]);
          miscompares++;
        end
      end
    end else if (sof) begin
      vectors++;
      $display("FAIL sof_alone: got sof=1 want 0 without pix_valid");
      miscompares++;
    end
    if (eol) begin eol_cnt++; last_eol_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  // driver tasks
  task automatic step(input logic fv, input logic lv, input logic [9:0] d);
    @(posedge clk); #1;
    cam_fv = fv; cam_lv = lv; cam_dout = d;
  endtask

  task automatic do_arm();
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
  endtask

  task automatic clear_counts();
    pix_cnt = 0; eol_cnt = 0; done_cnt = 0;
  endtask

  task automatic frame_open();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'(i));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 10'h155);  // lv without fv: must be ignored
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 10'd0);
  endtask

  task automatic drive_line(input int l, input int len, input bit exp_cap);
    for (int i = 0; i < len; i++) begin
      logic [9:0] d;
      d = 10'($urandom_range(0, 1023));
      step(1'b1, 1'b1, d);
      if (exp_cap) exp_q.push_back({(l == 0 && i == 0), 10'(l), 10'(i), d});
    end
  endtask

  task automatic frame_close(input bit same_fall);
    if (!same_fall) for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'd0);
  endtask

  task automatic run_frame(input int n, input bit same_fall, input bit exp_cap);
    frame_open();
    for (int l = 0; l < n; l++) begin
      drive_line(l, lens[l], exp_cap);
      if (l != n - 1) for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 10'd0);
    end
    frame_close(same_fall);
  endtask

  task automatic check_frame(input string tag, input int n, input bit exp_len, input bit exp_lines);
    @(negedge clk);
    vectors += 6;
    if (eol_cnt !== n) begin $display("FAIL %s eol_count: got %0d want %0d", tag, eol_cnt, n); miscompares++; end
    if (done_cnt !== 1) begin $display("FAIL %s done_count: got %0d want 1", tag, done_cnt); miscompares++; end
    if (frame_cnt !== exp_fc) begin $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, exp_fc); miscompares++; end
    if (err_len !== exp_len) begin $display("FAIL %s err_len: got %0b want %0b", tag, err_len, exp_len); miscompares++; end
    if (err_lines !== exp_lines) begin $display("FAIL %s err_lines: got %0b want %0b", tag, err_lines, exp_lines); miscompares++; end
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      $display("FAIL %s drain: got %0d pending busy=%0b want 0 pending busy=0", tag, exp_q.size(), busy);
      miscompares++;
      exp_q.delete();
    end
  endtask

  // scenarios
  task automatic test_reset();
    arm = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0);
    @(negedge clk);
    vectors += 3;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %0b want 0", busy); miscompares++; end
    if ({pix_valid, sof, eol, done, err_len, err_lines} !== 6'b0) begin
      $display("FAIL reset_flags: got %b want 000000", {pix_valid, sof, eol, done, err_len, err_lines}); miscompares++;
    end
    if ({frame_cnt, pix_data, pix_x, pix_y} !== 46'b0) begin
      $display("FAIL reset_data: got fc=%0d d=%0d x=%0d y=%0d want all 0", frame_cnt, pix_data, pix_x, pix_y); miscompares++;
    end
    @(posedge clk); #1 reset = 1'b0; arm = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin $display("FAIL reset_arm_ignored: got busy=%0b want 0", busy); miscompares++; end
  endtask

  task automatic test_full_frame();
    clear_counts();
    for (int l = 0; l < HEIGHT_P; l++) lens[l] = WIDTH_P;
    do_arm();
    run_frame(HEIGHT_P, 1'b0, 1'b1);
    exp_fc++;
    check_frame("full", HEIGHT_P, 1'b0, 1'b0);
    vectors += 2;
    if (pix_cnt !== WIDTH_P * HEIGHT_P) begin $display("FAIL full_pixels: got %0d want %0d", pix_cnt, WIDTH_P * HEIGHT_P); miscompares++; end
    if (last_x !== 10'(WIDTH_P - 1) || last_y !== 10'(HEIGHT_P - 1)) begin
      $display("FAIL full_last_xy: got %0d,%0d want %0d,%0d", last_x, last_y, WIDTH_P - 1, HEIGHT_P - 1); miscompares++;
    end
  endtask

  task automatic test_mid_frame_arm();
    clear_counts();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 10'd0);
    drive_line(0, 4, 1'b0);
    @(posedge clk); #1 arm = 1'b1;
    @(posedge clk); #1 arm = 1'b0;
    drive_line(1, WIDTH_P, 1'b0);
    step(1'b1, 1'b0, 10'd0);
    @(negedge clk);
    vectors += 2;
    if (busy !== 1'b1) begin $display("FAIL midarm_busy: got %0b want 1", busy); miscompares++; end
    if (pix_cnt !== 0) begin $display("FAIL midarm_no_pixels: got %0d want 0", pix_cnt); miscompares++; end
    for (int l = 0; l < HEIGHT_P; l++) lens[l] = WIDTH_P;
    run_frame(HEIGHT_P, 1'b0, 1'b1);
    exp_fc++;
    check_frame("midarm", HEIGHT_P, 1'b0, 1'b0);
  endtask

  task automatic test_short_line();
    clear_counts();
    for (int l = 0; l < HEIGHT_P; l++) lens[l] = WIDTH_P;
    lens[3] = WIDTH_P - 2;
    do_arm();
    run_frame(HEIGHT_P, 1'b0, 1'b1);
    exp_fc++;
    check_frame("shortline", HEIGHT_P, 1'b1, 1'b0);
    lens[3] = WIDTH_P;
    clear_counts();
    do_arm();
    @(negedge clk);
    vectors++;
    if (err_len !== 1'b0) begin $display("FAIL shortline_clear: got %0b want 0", err_len); miscompares++; end
    run_frame(HEIGHT_P, 1'b0, 1'b1);
    exp_fc++;
    check_frame("afterclear", HEIGHT_P, 1'b0, 1'b0);
  endtask

  task automatic test_short_frame();
    clear_counts();
    for (int l = 0; l < HEIGHT_P; l++) lens[l] = WIDTH_P;
    do_arm();
    run_frame(HEIGHT_P - 1, 1'b1, 1'b1);
    exp_fc++;
    check_frame("shortframe", HEIGHT_P - 1, 1'b0, 1'b1);
    vectors++;
    if (last_eol_cyc !== done_cyc) begin
      $display("FAIL shortframe_same_cycle: got eol@%0d done@%0d want equal", last_eol_cyc, done_cyc); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    do_arm();
    frame_open();
    for (int l = 0; l < 3; l++) begin
      drive_line(l, WIDTH_P, 1'b1);
      for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 10'd0);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    exp_fc = '0;
    vectors += 3;
    if (busy !== 1'b0) begin $display("FAIL abort_busy: got %0b want 0", busy); miscompares++; end
    if (frame_cnt !== exp_fc) begin $display("FAIL abort_frame_cnt: got %0d want %0d", frame_cnt, exp_fc); miscompares++; end
    if ({pix_x, pix_y, err_len, err_lines} !== 22'b0 || exp_q.size() !== 0) begin
      $display("FAIL abort_state: got x=%0d y=%0d errs=%b pending=%0d want 0", pix_x, pix_y, {err_len, err_lines}, exp_q.size());
      miscompares++;
      exp_q.delete();
    end
    for (int l = 3; l < HEIGHT_P; l++) begin
      drive_line(l, WIDTH_P, 1'b0);
      for (int g = 0; g < 3; g++) step(1'b1, 1'b0, 10'd0);
    end
    frame_close(1'b1);
    vectors++;
    if (done_cnt !== 0) begin $display("FAIL abort_no_done: got %0d want 0", done_cnt); miscompares++; end
    clear_counts();
    for (int l = 0; l < HEIGHT_P; l++) lens[l] = WIDTH_P;
    do_arm();
    run_frame(HEIGHT_P, 1'b0, 1'b1);
    exp_fc++;
    check_frame("postabort", HEIGHT_P, 1'b0, 1'b0);
  endtask

  task automatic test_latency();
    clear_counts();
    do_arm();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 10'd0);
    step(1'b1, 1'b1, 10'h2A5);
    exp_q.push_back({1'b1, 10'd0, 10'd0, 10'h2A5});
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b0) begin $display("FAIL latency_n0: got %0b want 0", pix_valid); miscompares++; end
    step(1'b1, 1'b0, 10'd0);
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b0) begin $display("FAIL latency_n1: got %0b want 0", pix_valid); miscompares++; end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b1 || pix_data !== 10'h2A5) begin
      $display("FAIL latency_n2: got v=%0b d=%h want v=1 d=2a5", pix_valid, pix_data); miscompares++;
    end
    frame_close(1'b0);
    exp_fc++;
    check_frame("latency", 1, (WIDTH_P != 1), (HEIGHT_P != 1));
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      int n;
      bit same, bad_len;
      string tag;
      n = $urandom_range(4, 7);
      same = $urandom_range(0, 1);
      bad_len = 1'b0;
      for (int l = 0; l < n; l++) begin
        lens[l] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WIDTH_P + 2) : WIDTH_P;
        if (lens[l] != WIDTH_P) bad_len = 1'b1;
      end
      clear_counts();
      do_arm();
      run_frame(n, same, 1'b1);
      exp_fc++;
      tag = $sformatf("rand%0d", f);
      check_frame(tag, n, bad_len, (n != HEIGHT_P));
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mid_frame_arm();
    test_short_line();
    test_short_frame();
    test_reset_mid();
    test_latency();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
